// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply/divide unit: iterative Booth multiply, restoring divide with sign fix-up.
// Optional macro MULTDIV_RADIX4_EN selects radix-4 Booth multiply (two multiplier bits per cycle).
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

`ifdef MULTDIV_RADIX4_EN
    localparam int MulIters = WIDTH / 2;
`else
    localparam int MulIters = WIDTH;
`endif
    localparam int CntW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } stateT;

    stateT state;
    stateT nextState;

    logic               startMul;
    logic               startDiv;
    logic               divZero;
    logic               divOverflow;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;

    logic [2*WIDTH:0]   acc;
    logic [2*WIDTH:0]   accNext;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] product;
    logic               mulOverflow;

    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   remNext;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   quoNext;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               negQuo;
    logic               ovfPend;

    logic [CntW-1:0]    count;
    logic               mulLast;
    logic               divLast;

    logic [WIDTH-1:0]   resultNext;
    logic               excNext;
    logic               rdyNext;
    logic               busyNext;

    assign startMul    = ctrl_MULT;
    assign startDiv    = ctrl_DIV & ~ctrl_MULT;
    assign divZero     = (data_operandB == '0);
    assign divOverflow = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
    assign absA        = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign absB        = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    assign mulLast     = (count == CntW'(MulIters - 1));
    assign divLast     = (count == CntW'(WIDTH - 1));

`ifdef MULTDIV_RADIX4_EN
    logic [WIDTH+1:0] upper4;
    logic [WIDTH+1:0] mOne;
    logic [WIDTH+1:0] mTwo;
    logic [WIDTH+1:0] boothSum;

    // Accumulator is {upper, multiplier, q-1}; sum is kept two bits wider so the
    // arithmetic shift by two always sees the true sign.
    always_comb begin
        upper4 = {{2{acc[2*WIDTH]}}, acc[2*WIDTH:WIDTH+1]};
        mOne   = {{2{mcand[WIDTH-1]}}, mcand};
        mTwo   = {mcand[WIDTH-1], mcand, 1'b0};
        case (acc[2:0])
            3'b001, 3'b010: boothSum = upper4 + mOne;
            3'b011:         boothSum = upper4 + mTwo;
            3'b100:         boothSum = upper4 - mTwo;
            3'b101, 3'b110: boothSum = upper4 - mOne;
            default:        boothSum = upper4;
        endcase
        accNext = {boothSum, acc[WIDTH:2]};
    end
`else
    logic [WIDTH:0] upper2;
    logic [WIDTH:0] mOne;
    logic [WIDTH:0] boothSum;

    // One extra sum bit lets the most-negative multiplicand be subtracted without
    // losing the sign that the arithmetic shift brings in.
    always_comb begin
        upper2 = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        mOne   = {mcand[WIDTH-1], mcand};
        case (acc[1:0])
            2'b01:   boothSum = upper2 + mOne;
            2'b10:   boothSum = upper2 - mOne;
            default: boothSum = upper2;
        endcase
        accNext = {boothSum, acc[WIDTH:1]};
    end
`endif

    assign product     = accNext[2*WIDTH:1];
    assign mulOverflow = (product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}});

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (diff[WIDTH]) begin
            remNext = shifted[WIDTH-1:0];
            quoNext = {quo[WIDTH-2:0], 1'b0};
        end else begin
            remNext = diff[WIDTH-1:0];
            quoNext = {quo[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A start pulse overrides whatever is in flight; outputs are computed here and registered below.
    always_comb begin
        nextState  = state;
        resultNext = data_result;
        excNext    = data_exception;
        rdyNext    = 1'b0;
        busyNext   = 1'b0;
        if (startMul) begin
            nextState = MUL;
            busyNext  = 1'b1;
        end else if (startDiv) begin
            if (divZero) begin
                nextState  = DONE;
                resultNext = '0;
                excNext    = 1'b1;
                rdyNext    = 1'b1;
            end else begin
                nextState = DIV;
                busyNext  = 1'b1;
            end
        end else begin
            case (state)
                MUL: begin
                    busyNext = 1'b1;
                    if (mulLast) begin
                        nextState  = DONE;
                        busyNext   = 1'b0;
                        rdyNext    = 1'b1;
                        resultNext = product[WIDTH-1:0];
                        excNext    = mulOverflow;
                    end
                end
                DIV: begin
                    busyNext = 1'b1;
                    if (divLast) begin
                        nextState = FIX;
                    end
                end
                FIX: begin
                    nextState  = DONE;
                    rdyNext    = 1'b1;
                    resultNext = negQuo ? (~quo + 1'b1) : quo;
                    excNext    = ovfPend;
                end
                DONE: begin
                    nextState = IDLE;
                end
                default: begin
                    nextState = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_result    <= resultNext;
            data_exception <= excNext;
            data_resultRDY <= rdyNext;
            busy           <= busyNext;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (startMul) begin
            acc   <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
            mcand <= data_operandA;
            count <= '0;
        end else if (startDiv) begin
            rem     <= '0;
            quo     <= absA;
            divisor <= absB;
            negQuo  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            ovfPend <= divOverflow;
            count   <= '0;
        end else if (state == MUL) begin
            acc   <= accNext;
            count <= count + CntW'(1);
        end else if (state == DIV) begin
            rem   <= remNext;
            quo   <= quoNext;
            count <= count + CntW'(1);
        end
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Multi-cycle signed 32-bit multiply/divide unit. It runs beside the single-cycle ALU in the execute stage.
- The ALU completes in one cycle. This block is the multi-cycle side: the pipeline issues one operation by start pulse, stalls on `busy`, and collects the result on a one-cycle ready strobe.
- Multiply uses iterative radix-2 Booth recoding. Divide uses iterative restoring division on magnitudes, followed by a sign-correction cycle.

Parameters:
- WIDTH, 32, operand/result width in bits. The iteration count equals WIDTH.

Ports:
- clock  input  1  sole clock; all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clock
- data_operandA  input  WIDTH  multiplicand / dividend, sampled on start cycle only
- data_operandB  input  WIDTH  multiplier / divisor, sampled on start cycle only
- ctrl_MULT  input  1  single-cycle start pulse for multiply
- ctrl_DIV  input  1  single-cycle start pulse for divide
- data_result  output  WIDTH  product low word or quotient; held until next start or reset
- data_exception  output  1  overflow / divide-by-zero flag; valid and held with data_result
- data_resultRDY  output  1  one-cycle strobe: data_result and data_exception are valid
- busy  output  1  high while an operation is in flight

Behaviour:
- Reset: reset_n low at a rising edge forces state IDLE and clears all outputs (data_result=0, data_exception=0, data_resultRDY=0, busy=0). This is synchronous only and takes effect regardless of any operation in flight. Any aborted operation never strobes ready.
- States: IDLE, MUL, DIV, FIX, DONE.
- Start: ctrl_MULT or ctrl_DIV is sampled at edge 0. Operands are latched at that edge. busy rises in cycle 1. data_resultRDY drops.
- If both starts are high in the same cycle, multiply wins.
- A start pulse in any state, including mid-operation or DONE, aborts the current operation and restarts with the new operands. The aborted operation produces no ready strobe.
- MUL: performs WIDTH Booth iterations over a 2*WIDTH+1 accumulator, then moves to DONE. data_resultRDY is high in cycle WIDTH+1 (33 at default).
  - data_result = low WIDTH bits of the signed product.
  - data_exception = 1 when the full 2*WIDTH product is not the sign-extension of its low word.
- DIV: takes absolute values of both operands, performs WIDTH restoring iterations, then FIX negates the quotient if the operand signs differ. data_resultRDY is high in cycle WIDTH+2 (34 at default).
  - Quotient truncates toward zero. The remainder is discarded.
- Divide by zero: detected at start. State goes directly to DONE. data_resultRDY is high in cycle 1, with data_result=0 and data_exception=1.
- Signed-overflow divide (most-negative value / -1): full latency. data_result=most-negative value, data_exception=1.
- DONE: data_resultRDY=1 for exactly one cycle, then the state returns to IDLE. busy=0 in DONE.
- Results hold stable in IDLE.
- Outputs are registered. No combinational path exists from inputs to outputs.

Optional Feature:
- MULTDIV_RADIX4_EN
  - Defined: multiply uses radix-4 Booth recoding, two bits per cycle. data_resultRDY arrives in cycle WIDTH/2+1 (17 at default). WIDTH must be even.
  - Undefined: radix-2 multiply, ready in cycle WIDTH+1.
  - Divide timing, results and exception behaviour are identical in both builds.

Test Plan:
- ctrl_MULT with A=7, B=-3 (0xFFFFFFFD) -> ready in cycle 33 (17 with radix-4): data_result=0xFFFFFFEB, data_exception=0; busy high in cycles 1-32.
- ctrl_MULT with A=0x00010000, B=0x00010000 -> data_result=0x00000000, data_exception=1.
- ctrl_DIV with A=-7 (0xFFFFFFF9), B=2 -> ready in cycle 34: data_result=0xFFFFFFFD, data_exception=0.
  - A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_exception=1.
- ctrl_DIV with A=5, B=0 -> ready in cycle 1: data_result=0, data_exception=1; busy never high.
- ctrl_MULT 3*4 at cycle 0, then ctrl_DIV 100/7 at cycle 10 -> no ready strobe at cycle 33; ready in cycle 44 with data_result=14.
- ctrl_MULT at cycle 0, reset_n low at edge 5 -> all outputs 0 from cycle 6; no ready strobe.
